// File: rtl/dpi_rs.sv
// Reservation station feeding the data-processing-immediate FU: age-matrix oldest-ready select
// with writeback wakeup. Define DPI_RS_PERF_CNT_EN to add issue/stall performance counters.
module dpi_rs #(
  parameter int DEPTH = 4,
  parameter int PRN_W = 7,
  parameter int ID_W  = 6,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  disp_valid,
  output logic                  disp_ready,
  input  logic [31:0]           disp_inst,
  input  logic [ID_W-1:0]       disp_inst_id,
  input  logic [PRN_W-1:0]      disp_out_prn,
  input  logic [2*PRN_W-1:0]    disp_src_prn,
  input  logic [1:0]            disp_src_rdy,
  input  logic [127:0]          disp_src_data,
  input  logic                  wb_valid,
  input  logic [PRN_W-1:0]      wb_prn,
  input  logic [63:0]           wb_data,
  output logic                  iss_valid,
  input  logic                  fu_ready,
  output logic [31:0]           iss_inst,
  output logic [ID_W-1:0]       iss_inst_id,
  output logic [PRN_W-1:0]      iss_out_prn,
  output logic [127:0]          iss_op,
`ifdef DPI_RS_PERF_CNT_EN
  output logic [CNT_W-1:0]      count,
  output logic [31:0]           perf_issue_cnt,
  output logic [31:0]           perf_stall_cnt
`else
  output logic [CNT_W-1:0]      count
`endif
);

  logic [DEPTH-1:0] valid_reg;
  logic [1:0]       rdy_reg     [DEPTH];
  logic [DEPTH-1:0] older_reg   [DEPTH];  // older_reg[i][j]: entry i is older than entry j
  logic [31:0]      inst_reg    [DEPTH];
  logic [ID_W-1:0]  id_reg      [DEPTH];
  logic [PRN_W-1:0] out_prn_reg [DEPTH];
  logic [PRN_W-1:0] src_prn_reg [DEPTH][2];
  logic [63:0]      data_reg    [DEPTH][2];
  logic [CNT_W-1:0] count_reg;

  logic             iss_valid_reg;
  logic [31:0]      iss_inst_reg;
  logic [ID_W-1:0]  iss_id_reg;
  logic [PRN_W-1:0] iss_prn_reg;
  logic [127:0]     iss_op_reg;

  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] sel;
  logic [DEPTH-1:0] older_col [DEPTH];
  logic [1:0]       wake      [DEPTH];
  logic [1:0]       disp_wake;
  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic             disp_fire;
  logic             issue_load;

  assign disp_ready = (count_reg != CNT_W'(DEPTH));
  assign disp_fire  = disp_valid & disp_ready;
  assign issue_load = (~iss_valid_reg | fu_ready) & (|cand);

  assign disp_wake[0] = ~disp_src_rdy[0] & wb_valid & (wb_prn == disp_src_prn[PRN_W-1:0]);
  assign disp_wake[1] = ~disp_src_rdy[1] & wb_valid & (wb_prn == disp_src_prn[2*PRN_W-1:PRN_W]);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        older_col[i][j] = older_reg[j][i];
      end
    end
  end

  // Readiness comes from registered rdy only, so a same-edge wakeup is eligible next cycle.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign cand[gi] = valid_reg[gi] & (&rdy_reg[gi]);
    assign sel[gi]  = cand[gi] & ~(|(cand & older_col[gi]));
    assign wake[gi] = {valid_reg[gi] & ~rdy_reg[gi][1] & wb_valid & (wb_prn == src_prn_reg[gi][1]),
                       valid_reg[gi] & ~rdy_reg[gi][0] & wb_valid & (wb_prn == src_prn_reg[gi][0])};
  end

  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_reg[i]) alloc_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  // Payload has no reset: it is only observed through valid/rdy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (disp_fire && alloc_idx == IDX_W'(i)) begin
        inst_reg[i]       <= disp_inst;
        id_reg[i]         <= disp_inst_id;
        out_prn_reg[i]    <= disp_out_prn;
        src_prn_reg[i][0] <= disp_src_prn[PRN_W-1:0];
        src_prn_reg[i][1] <= disp_src_prn[2*PRN_W-1:PRN_W];
        data_reg[i][0]    <= disp_wake[0] ? wb_data : disp_src_data[63:0];
        data_reg[i][1]    <= disp_wake[1] ? wb_data : disp_src_data[127:64];
      end else begin
        if (wake[i][0]) data_reg[i][0] <= wb_data;
        if (wake[i][1]) data_reg[i][1] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= '0;
      count_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rdy_reg[i]   <= '0;
        older_reg[i] <= '0;
      end
    end else if (flush) begin
      valid_reg <= '0;
      count_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_load && sel[i]) valid_reg[i] <= 1'b0;
        if (disp_fire && alloc_idx == IDX_W'(i)) begin
          valid_reg[i]    <= 1'b1;
          rdy_reg[i]      <= disp_src_rdy | disp_wake;
          older_reg[i]    <= '0;
        end else begin
          rdy_reg[i]      <= rdy_reg[i] | wake[i];
          // Every other entry is older than the newcomer; stale bits of free entries are rewritten on reuse.
          if (disp_fire) older_reg[i][alloc_idx] <= 1'b1;
        end
      end
      case ({disp_fire, issue_load})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_reg <= 1'b0;
      iss_inst_reg  <= '0;
      iss_id_reg    <= '0;
      iss_prn_reg   <= '0;
      iss_op_reg    <= '0;
    end else if (flush) begin
      iss_valid_reg <= 1'b0;
    end else if (issue_load) begin
      iss_valid_reg <= 1'b1;
      iss_inst_reg  <= inst_reg[sel_idx];
      iss_id_reg    <= id_reg[sel_idx];
      iss_prn_reg   <= out_prn_reg[sel_idx];
      iss_op_reg    <= {data_reg[sel_idx][1], data_reg[sel_idx][0]};
    end else begin
      iss_valid_reg <= iss_valid_reg & ~fu_ready;
    end
  end

  assign iss_valid   = iss_valid_reg;
  assign iss_inst    = iss_inst_reg;
  assign iss_inst_id = iss_id_reg;
  assign iss_out_prn = iss_prn_reg;
  assign iss_op      = iss_op_reg;
  assign count       = count_reg;

`ifdef DPI_RS_PERF_CNT_EN
  logic [31:0] perf_issue_reg;
  logic [31:0] perf_stall_reg;

  // Counters ignore flush so they span squashes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_issue_reg <= '0;
      perf_stall_reg <= '0;
    end else begin
      if (iss_valid_reg && fu_ready) perf_issue_reg <= perf_issue_reg + 32'd1;
      if (!disp_ready && disp_valid) perf_stall_reg <= perf_stall_reg + 32'd1;
    end
  end

  assign perf_issue_cnt = perf_issue_reg;
  assign perf_stall_cnt = perf_stall_reg;
`else
`endif

endmodule
